alu_result_buffer: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_result_flags.sv | 28 ++
 rtl/alu_result_buffer.sv | 122 ++++++++++++
 tb/tb_alu_result_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path: function-code encodings
// (in_f[3:1]), the result width and the packed entry stored in the result buffer.
package alu_pkg;

    localparam int RES_W = 32;
    localparam int FN_W  = 4;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_MUL = 3'd2;
    localparam logic [2:0] F_SHR = 3'd3;
    localparam logic [2:0] F_SHL = 3'd4;

    // in_f[0] qualifies the base operation (increment/carry-in variant).
    localparam int F_INC_BIT = 0;

    typedef struct packed {
        logic [RES_W-1:0] r;
        logic [FN_W-1:0]  f;
        logic             zero;
        logic             neg;
        logic             shift;
    } alu_entry_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == F_SHR) || (op == F_SHL);
    endfunction

endpackage

// File: rtl/alu_result_flags.sv
// Combinational flag generator: packs an ALU result and its function code into
// a buffer entry with zero / negative / shift status.
module alu_result_flags
    import alu_pkg::*;
(
    input  logic [RES_W-1:0] r,
    input  logic [FN_W-1:0]  f,
    output alu_entry_t       entry
);

    logic [2:0] op;
    logic       unused_arith;

    assign op = f[3:1];

    // Arithmetic codes and the increment qualifier carry no flag of their own.
    assign unused_arith = (op == F_ADD) | (op == F_SUB) | (op == F_MUL) | f[F_INC_BIT];

    always_comb begin
        entry       = '0;
        entry.r     = r;
        entry.f     = f;
        entry.zero  = (r == '0);
        entry.neg   = r[RES_W-1];
        entry.shift = is_shift_op(op);
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Result FIFO behind the combinational ALU with valid/ready on both sides.
// Optional ALU_RESULT_BYPASS_EN: empty-buffer results are presented to the consumer in the same cycle.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_r,
    input  logic [FN_W-1:0]  in_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_r,
    output logic [FN_W-1:0]  out_f,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_shift,
    output logic [CW-1:0]    count,
    output logic             ovf_err
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends only on registered occupancy, never on out_ready.
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    alu_entry_t    mem_q [DEPTH];
    alu_entry_t    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    alu_entry_t    in_entry;
    alu_entry_t    head_entry;
    logic          push;
    logic          store;
    logic          pop_mem;
    logic          out_valid_int;
    logic          empty;

    alu_result_flags u_flags (
        .r     (in_r),
        .f     (in_f),
        .entry (in_entry)
    );

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid & in_ready;

`ifdef ALU_RESULT_BYPASS_EN
    logic bypass_sel;

    // An empty buffer forwards the incoming result; if consumed now it never touches storage.
    assign bypass_sel    = empty & in_valid;
    assign out_valid_int = ~empty | in_valid;
    assign head_entry    = bypass_sel ? in_entry : mem_q[rd_ptr_q];
    assign pop_mem       = ~empty & out_ready;
    assign store         = push & ~(bypass_sel & out_ready);
`else
    assign out_valid_int = ~empty;
    assign head_entry    = mem_q[rd_ptr_q];
    assign pop_mem       = out_valid_int & out_ready;
    assign store         = push;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (in_valid & ~in_ready);

        if (store) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (pop_mem) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({store, pop_mem})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = out_valid_int;
    assign out_r     = head_entry.r;
    assign out_f     = head_entry.f;
    assign out_zero  = head_entry.zero;
    assign out_neg   = head_entry.neg;
    assign out_shift = head_entry.shift;
    assign count     = count_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer (DEPTH=4), both default and
// ALU_RESULT_BYPASS_EN builds.
module tb_alu_result_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef ALU_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_r;
    logic [3:0]    in_f;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_r;
    logic [3:0]    out_f;
    logic          out_zero;
    logic          out_neg;
    logic          out_shift;
    logic [CW-1:0] count;
    logic          ovf_err;

    int total = 0;
    int bad   = 0;

    // Scoreboard entries: {r, f, zero, neg, shift}
    logic [38:0] exp_q[$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic        m_rdy, m_ov;
    logic [38:0] exp_e, act_e;

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_f      (in_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_f     (out_f),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_shift (out_shift),
        .count     (count),
        .ovf_err   (ovf_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] model_entry(input logic [31:0] r, input logic [3:0] f);
        logic z, n, s;
        z = (r == 32'd0);
        n = r[31];
        s = (f[3:1] == 3'd3) || (f[3:1] == 3'd4);
        return {r, f, z, n, s};
    endfunction

    // ---------------- scoreboard monitor (negedge sampling) ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            m_rdy = (m_cnt != DEPTH);
            m_ov  = (m_cnt != 0) || (BYP && in_valid);
            total++;
            if (count !== CW'(m_cnt)) begin
                bad++;
                $display("FAIL mon_count: got %0d want %0d at %0t", count, m_cnt, $time);
            end
            total++;
            if (in_ready !== m_rdy || out_valid !== m_ov || ovf_err !== m_ovf) begin
                bad++;
                $display("FAIL mon_status: got rdy=%b ov=%b ovf=%b want rdy=%b ov=%b ovf=%b at %0t",
                         in_ready, out_valid, ovf_err, m_rdy, m_ov, m_ovf, $time);
            end
            if (in_valid && !m_rdy) m_ovf = 1'b1;
            if (in_valid && m_rdy) begin
                exp_q.push_back(model_entry(in_r, in_f));
                m_cnt++;
            end
            if (m_ov && out_ready) begin
                total++;
                act_e = {out_r, out_f, out_zero, out_neg, out_shift};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_pop_empty: got %h want no pop at %0t", act_e, $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    m_cnt--;
                    if (act_e !== exp_e) begin
                        bad++;
                        $display("FAIL mon_data: got %h want %h at %0t", act_e, exp_e, $time);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        clear_model();
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] r, input logic [3:0] f);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_r     = r;
        in_f     = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (m_cnt != 0 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        total++;
        if (m_cnt != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d left want 0", m_cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_r      = '0;
        in_f      = '0;
        #3;
        total++;
        if ({count, out_valid, ovf_err, in_ready} !== {CW'(0), 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_status: got cnt=%0d ov=%b ovf=%b rdy=%b want 0 0 0 1",
                     count, out_valid, ovf_err, in_ready);
        end
        total++;
        if ({out_r, out_f, out_zero, out_neg, out_shift} !== 39'd0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {out_r, out_f, out_zero, out_neg, out_shift});
        end
        #10;
        rst_n = 1'b1;
        clear_model();

        // Mid-stream asynchronous reset with 3 entries buffered.
        for (int i = 1; i <= 3; i++) push_one(32'h100 + i, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({count, out_valid, ovf_err, in_ready} !== {CW'(0), 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: got cnt=%0d ov=%b ovf=%b rdy=%b want 0 0 0 1",
                     count, out_valid, ovf_err, in_ready);
        end
        clear_model();
        #1;
        rst_n = 1'b1;
        push_one(32'h0000_00A5, 4'h2);
        total++;
        if (count !== CW'(1) || out_r !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL post_reset_head: got cnt=%0d r=%h want 1 000000a5", count, out_r);
        end
        drain();
    endtask

    task automatic test_fill_overflow();
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_r     = i;
            in_f     = 4'h0;
            @(posedge clk);
            #1;
        end
        in_r = 32'd5;
        total++;
        if (in_ready !== 1'b0 || count !== CW'(4)) begin
            bad++;
            $display("FAIL fill_full: got rdy=%b cnt=%0d want 0 4", in_ready, count);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL fill_ovf: got %b want 1", ovf_err);
        end
        drain();
    endtask

    task automatic test_flags();
        logic [2:0] want [3];
        want[0] = 3'b100;
        want[1] = 3'b010;
        want[2] = 3'b001;
        do_reset();
        push_one(32'd0, 4'b0010);
        push_one(32'h8000_0000, 4'b0100);
        push_one(32'd7, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({out_zero, out_neg, out_shift} !== want[i]) begin
                bad++;
                $display("FAIL flags_%0d: got %b want %b", i, {out_zero, out_neg, out_shift}, want[i]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_one(32'hA000_0001, 4'h6);
        push_one(32'hA000_0002, 4'h8);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_r     = $urandom;
            in_f     = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            total++;
            if (count !== CW'(2)) begin
                bad++;
                $display("FAIL b2b_count: got %0d want 2 cycle %0d", count, i);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drain();
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'hC0 + i, 4'h2);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_r      = 32'hDEAD_0005;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (count !== CW'(3) || ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL full_pop: got cnt=%0d ovf=%b want 3 1", count, ovf_err);
        end
        drain();
    endtask

    task automatic test_latency();
        do_reset();
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_r      = 32'hDEAD_BEEF;
        in_f      = 4'h0;
        out_ready = 1'b1;
        #1;
`ifdef ALU_RESULT_BYPASS_EN
        total++;
        if (out_valid !== 1'b1 || out_r !== 32'hDEAD_BEEF || count !== CW'(0)) begin
            bad++;
            $display("FAIL bypass_same: got ov=%b r=%h cnt=%0d want 1 deadbeef 0", out_valid, out_r, count);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (count !== CW'(0) || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bypass_after: got cnt=%0d ov=%b want 0 0", count, out_valid);
        end
`else
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_same: got ov=%b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_r !== 32'hDEAD_BEEF || count !== CW'(1)) begin
            bad++;
            $display("FAIL latency_next: got ov=%b r=%h cnt=%0d want 1 deadbeef 1", out_valid, out_r, count);
        end
        drain();
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fill_overflow();
        test_flags();
        test_back_to_back();
        test_full_pop();
        test_latency();
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
